mapper_burst_ctrl: RTL and testbench

//  Burst sequencer for const_mapping. Accepts one burst descriptor (rate_id, OFDM symbol count),

---
 rtl/mapper_pkg.sv | 29 ++
 rtl/mapper_slot_cnt.sv | 40 ++++
 rtl/mapper_burst_ctrl.sv | 138 +++++++++++++
 tb/tb_mapper_burst_ctrl.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/mapper_pkg.sv
// Shared types and constants for the 256-OFDM mapper burst sequencer.
// bpc() gives coded bits per carrier for a WiMAX rate_id.
package mapper_pkg;

  typedef logic [4:0] rate_id_t;

  localparam rate_id_t RATE_ID_MAX  = 5'd6;
  localparam int       DATA_CAR_256 = 192;
  localparam int       PILOT_SP_256 = 25;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    FLUSH = 2'd2,
    DONE  = 2'd3
  } state_t;

  function automatic logic [2:0] bpc(input rate_id_t rid);
    logic [2:0] b;
    case (rid)
      5'd0:       b = 3'd1;
      5'd1, 5'd2: b = 3'd2;
      5'd3, 5'd4: b = 3'd4;
      default:    b = 3'd6;
    endcase
    return b;
  endfunction

endpackage

// File: rtl/mapper_slot_cnt.sv
// Slot index within an OFDM symbol: wraps after SLOTS-1, flags first/last slot and pilot slots.
// Strobes are combinational with the current slot and only asserted while active.
module mapper_slot_cnt
  import mapper_pkg::*;
#(
  parameter int SLOTS    = DATA_CAR_256,
  parameter int PILOT_SP = PILOT_SP_256,
  parameter bit PILOT_EN = 1'b0
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       active,
  input  logic       adv,
  input  logic       clear,
  output logic [7:0] car_idx,
  output logic       sym_start,
  output logic       sym_end,
  output logic       pilot_slot
);

  localparam logic [7:0] LAST = 8'(SLOTS - 1);
  localparam logic [7:0] SP   = 8'(PILOT_SP);
  localparam logic [7:0] HALF = 8'(PILOT_SP / 2);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      car_idx <= '0;
    end else if (clear) begin
      car_idx <= '0;
    end else if (adv) begin
      car_idx <= (car_idx == LAST) ? 8'd0 : car_idx + 8'd1;
    end
  end

  assign sym_start  = active & (car_idx == 8'd0);
  assign sym_end    = active & (car_idx == LAST);
  // Without pilots PILOT_EN folds this to a constant 0.
  assign pilot_slot = active & PILOT_EN & ((car_idx % SP) == HALF);

endmodule

// File: rtl/mapper_burst_ctrl.sv
// Burst sequencer for const_mapping: admits exactly the coded bits a burst needs and paces carriers downstream.
// Backpressure passes straight through (src_ready/map_out_ready); MAPCTL_PILOT_EN inserts pilot slots.
module mapper_burst_ctrl
  import mapper_pkg::*;
#(
  parameter int IN_BITS  = 2,
  parameter int SYM_W    = 8,
  parameter int DATA_CAR = DATA_CAR_256,
  parameter int PILOT_SP = PILOT_SP_256
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             cfg_valid,
  output logic             cfg_ready,
  input  logic [4:0]       cfg_rate_id,
  input  logic [SYM_W-1:0] cfg_num_sym,
  output logic             cfg_err,
  input  logic             src_valid,
  output logic             src_ready,
  output logic             map_in_valid,
  input  logic             map_ready,
  output logic [4:0]       map_rate_id,
  input  logic             map_out_valid,
  output logic             map_out_ready,
  input  logic             dn_ready,
  output logic [7:0]       car_idx,
  output logic             sym_start,
  output logic             sym_end,
  output logic             pilot_slot,
  output logic             burst_done,
  output logic             busy
);

`ifdef MAPCTL_PILOT_EN
  localparam bit PILOT_EN = 1'b1;
`else
  localparam bit PILOT_EN = 1'b0;
`endif

  localparam int SLOTS = PILOT_EN ? DATA_CAR + DATA_CAR / (PILOT_SP - 1) : DATA_CAR;
  localparam int BL_W  = SYM_W + 11;
  localparam int CL_W  = SYM_W + 8;

  localparam logic [BL_W-1:0] IN_BITS_W = BL_W'(IN_BITS);
  localparam logic [CL_W-1:0] CAR_ONE   = CL_W'(1);

  state_t          state;
  logic [BL_W-1:0] bits_left;
  logic [CL_W-1:0] car_left;
  logic [BL_W-1:0] bits_init;
  logic [CL_W-1:0] car_init;
  logic [BL_W-1:0] bits_nxt;
  logic            admit_en;
  logic            drain;
  logic            src_fire;
  logic            car_fire;
  logic            slot_adv;
  logic            cfg_fire;

  assign admit_en  = (state == RUN);
  assign drain     = (state == RUN) || (state == FLUSH);
  assign cfg_ready = (state == IDLE);
  assign busy      = (state != IDLE);
  assign burst_done = (state == DONE);

  assign src_ready     = map_ready & admit_en;
  assign map_in_valid  = src_valid & admit_en;
  assign map_out_ready = dn_ready & drain & ~pilot_slot;

  assign cfg_fire = cfg_valid & cfg_ready;
  assign src_fire = src_valid & src_ready;
  assign car_fire = map_out_valid & map_out_ready;
  // Pilot slots carry no mapper output, so they advance on downstream readiness alone.
  assign slot_adv = drain & (pilot_slot ? dn_ready : car_fire);

  assign car_init  = CL_W'(cfg_num_sym) * CL_W'(DATA_CAR);
  assign bits_init = BL_W'(car_init) * BL_W'(bpc(cfg_rate_id));
  // A final partial beat is admitted whole; the mapper discards the surplus bits.
  assign bits_nxt  = (bits_left > IN_BITS_W) ? bits_left - IN_BITS_W : '0;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      bits_left   <= '0;
      car_left    <= '0;
      map_rate_id <= '0;
      cfg_err     <= 1'b0;
    end else begin
      cfg_err <= 1'b0;
      case (state)
        IDLE: begin
          if (cfg_valid) begin
            if (cfg_rate_id > RATE_ID_MAX) begin
              cfg_err <= 1'b1;
            end else begin
              map_rate_id <= cfg_rate_id;
              if (cfg_num_sym == '0) begin
                state <= DONE;
              end else begin
                bits_left <= bits_init;
                car_left  <= car_init;
                state     <= RUN;
              end
            end
          end
        end
        RUN, FLUSH: begin
          if (src_fire) bits_left <= bits_nxt;
          if (car_fire) car_left <= car_left - CAR_ONE;
          if (car_fire && car_left == CAR_ONE) begin
            state <= DONE;
          end else if (state == RUN && src_fire && bits_nxt == '0) begin
            state <= FLUSH;
          end
        end
        DONE: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  mapper_slot_cnt #(
    .SLOTS    (SLOTS),
    .PILOT_SP (PILOT_SP),
    .PILOT_EN (PILOT_EN)
  ) u_slot_cnt (
    .clk        (clk),
    .reset      (reset),
    .active     (drain),
    .adv        (slot_adv),
    .clear      (cfg_fire),
    .car_idx    (car_idx),
    .sym_start  (sym_start),
    .sym_end    (sym_end),
    .pilot_slot (pilot_slot)
  );

endmodule

// File: tb/tb_mapper_burst_ctrl.sv
// Bench for mapper_burst_ctrl: behavioural mapper model plus a queue of expected slot records per burst.
module tb_mapper_burst_ctrl;

  localparam int DATA_CAR = 192;
  localparam int PILOT_SP = 25;
`ifdef MAPCTL_PILOT_EN
  localparam int SLOTS = 200;
  localparam bit PIL   = 1'b1;
`else
  localparam int SLOTS = 192;
  localparam bit PIL   = 1'b0;
`endif

  logic       clk;
  logic       reset;
  logic       cfg_valid;
  logic       cfg_ready;
  logic [4:0] cfg_rate_id;
  logic [7:0] cfg_num_sym;
  logic       cfg_err;
  logic       src_valid;
  logic       src_ready;
  logic       map_in_valid;
  logic       map_ready;
  logic [4:0] map_rate_id;
  logic       map_out_valid;
  logic       map_out_ready;
  logic       dn_ready;
  logic [7:0] car_idx;
  logic       sym_start;
  logic       sym_end;
  logic       pilot_slot;
  logic       burst_done;
  logic       busy;

  mapper_burst_ctrl dut (
    .clk           (clk),
    .reset         (reset),
    .cfg_valid     (cfg_valid),
    .cfg_ready     (cfg_ready),
    .cfg_rate_id   (cfg_rate_id),
    .cfg_num_sym   (cfg_num_sym),
    .cfg_err       (cfg_err),
    .src_valid     (src_valid),
    .src_ready     (src_ready),
    .map_in_valid  (map_in_valid),
    .map_ready     (map_ready),
    .map_rate_id   (map_rate_id),
    .map_out_valid (map_out_valid),
    .map_out_ready (map_out_ready),
    .dn_ready      (dn_ready),
    .car_idx       (car_idx),
    .sym_start     (sym_start),
    .sym_end       (sym_end),
    .pilot_slot    (pilot_slot),
    .burst_done    (burst_done),
    .busy          (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;
  int cyc = 0;
  int stall = 0;
  int mdl_bits, mdl_bpc, mdl_car;
  int n_beats, n_symend, n_done, last_car_cyc;
  logic [10:0] exp_q[$];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic int bpc_of(input int rid);
    if (rid == 0) return 1;
    if (rid <= 2) return 2;
    if (rid <= 4) return 4;
    return 6;
  endfunction

  // One clock: drive at the falling edge, observe handshakes that will commit at the next rising edge.
  task automatic step();
    logic [10:0] got;
    @(negedge clk);
    cfg_valid     = 1'b0;
    src_valid     = ($urandom_range(0, 99) >= stall);
    map_ready     = ($urandom_range(0, 99) >= stall);
    dn_ready      = ($urandom_range(0, 99) >= stall);
    map_out_valid = (mdl_bpc > 0) && ((mdl_bits / mdl_bpc) > mdl_car);
    #1;
    if (src_valid && src_ready) begin
      mdl_bits += 2;
      n_beats++;
    end
    if ((map_out_valid && map_out_ready) || (pilot_slot && dn_ready)) begin
      got = {pilot_slot, sym_start, sym_end, car_idx};
      if (exp_q.size() == 0) chk("slot_q_nonempty", exp_q.size(), 1);
      else chk("slot", got, exp_q.pop_front());
      if (sym_end) n_symend++;
    end
    if (map_out_valid && map_out_ready) begin
      mdl_car++;
      last_car_cyc = cyc;
    end
    if (burst_done) begin
      n_done++;
      chk("done_latency", cyc - last_car_cyc, 1);
    end
    cyc++;
  endtask

  task automatic start_burst(input int rid, input int nsym, input int st);
    stall = st;
    @(negedge clk);
    src_valid     = 1'b0;
    map_out_valid = 1'b0;
    cfg_valid     = 1'b1;
    cfg_rate_id   = 5'(rid);
    cfg_num_sym   = 8'(nsym);
    #1;
    chk("cfg_ready", cfg_ready, 1);
    mdl_bpc      = bpc_of(rid);
    mdl_bits     = 0;
    mdl_car      = 0;
    n_beats      = 0;
    n_symend     = 0;
    n_done       = 0;
    last_car_cyc = cyc - 1;
    exp_q.delete();
    for (int s = 0; s < nsym; s++) begin
      for (int i = 0; i < SLOTS; i++) begin
        exp_q.push_back({PIL && ((i % PILOT_SP) == PILOT_SP / 2), i == 0, i == SLOTS - 1, 8'(i)});
      end
    end
  endtask

  task automatic finish_burst(input int rid, input int nsym);
    for (int t = 0; t < 20000 && n_done == 0; t++) step();
    repeat (3) step();
    chk("done_count", n_done, 1);
    chk("beats", n_beats, nsym * DATA_CAR * bpc_of(rid) / 2);
    chk("carriers", mdl_car, nsym * DATA_CAR);
    chk("sym_end_count", n_symend, nsym);
    chk("slots_left", exp_q.size(), 0);
    chk("busy_after", busy, 0);
    chk("map_rate_id", map_rate_id, rid);
  endtask

  initial begin
    reset         = 1'b1;
    cfg_valid     = 1'b0;
    cfg_rate_id   = '0;
    cfg_num_sym   = '0;
    src_valid     = 1'b0;
    map_ready     = 1'b0;
    map_out_valid = 1'b0;
    dn_ready      = 1'b0;
    mdl_bpc       = 0;
    mdl_bits      = 0;
    mdl_car       = 0;
    repeat (3) @(negedge clk);
    #1;
    chk("rst_cfg_ready", cfg_ready, 1);
    chk("rst_busy", busy, 0);
    chk("rst_car_idx", car_idx, 0);
    chk("rst_strobes", {sym_start, sym_end, pilot_slot, burst_done, cfg_err}, 0);
    chk("rst_rate_id", map_rate_id, 0);
    reset = 1'b0;

    // Single symbol, everything ready.
    start_burst(1, 1, 0);
    finish_burst(1, 1);

    // Three symbols at 6 bits/carrier.
    start_burst(5, 3, 0);
    finish_burst(5, 3);

    // Invalid rate_id is dropped with a one-cycle error pulse.
    @(negedge clk);
    cfg_valid   = 1'b1;
    cfg_rate_id = 5'd7;
    cfg_num_sym = 8'd1;
    @(negedge clk);
    cfg_valid = 1'b0;
    #1;
    chk("cfg_err_pulse", cfg_err, 1);
    chk("err_busy", busy, 0);
    @(negedge clk);
    #1;
    chk("cfg_err_clear", cfg_err, 0);
    chk("err_rate_id_kept", map_rate_id, 5);

    // Empty burst: done pulse, no carriers.
    start_burst(4, 0, 0);
    finish_burst(4, 0);

    // Random stalls on every handshake.
    start_burst(3, 2, 30);
    finish_burst(3, 2);

    // Asynchronous reset in the middle of a burst.
    start_burst(2, 1, 0);
    for (int t = 0; t < 5000 && mdl_car < 100; t++) step();
    chk("pre_reset_busy", busy, 1);
    reset = 1'b1;
    #1;
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_cfg_ready", cfg_ready, 1);
    chk("mid_rst_car_idx", car_idx, 0);
    chk("mid_rst_rate_id", map_rate_id, 0);
    chk("mid_rst_readies", {src_ready, map_out_ready, map_in_valid}, 0);
    chk("mid_rst_strobes", {sym_start, sym_end, pilot_slot, burst_done, cfg_err}, 0);
    src_valid     = 1'b0;
    map_out_valid = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    start_burst(0, 1, 10);
    finish_burst(0, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
